// File: rtl/lsu_axi_master.sv
// Data-memory AXI4-Lite master: one load/store at a time, stalls the pipeline until the response.
// Optional error reporting on SLVERR/DECERR is enabled by defining LSU_AXI_ERR_EN.
module lsu_axi_master #(
    parameter logic [31:0] AXI_BASE = 32'h4000_0000,
    parameter logic [31:0] AXI_MASK = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic [31:0] mem_rdata_o,
    output logic        m_axi_stall_o,
    output logic [31:0] m_axi_awaddr_o,
    output logic        m_axi_awvalid_o,
    input  logic        m_axi_awready_i,
    output logic [31:0] m_axi_wdata_o,
    output logic [3:0]  m_axi_wstrb_o,
    output logic        m_axi_wvalid_o,
    input  logic        m_axi_wready_i,
    input  logic [1:0]  m_axi_bresp_i,
    input  logic        m_axi_bvalid_i,
    output logic        m_axi_bready_o,
    output logic [31:0] m_axi_araddr_o,
    output logic        m_axi_arvalid_o,
    input  logic        m_axi_arready_i,
    input  logic [31:0] m_axi_rdata_i,
    input  logic [1:0]  m_axi_rresp_i,
    input  logic        m_axi_rvalid_i,
    output logic        m_axi_rready_o,
    output logic        err_o,
    output logic [31:0] err_addr_o
);

    typedef enum logic [2:0] {IDLE, WR, WB, RD, RR, DONE} state_t;

    state_t      state_reg, state_next;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wstrb_reg;
    logic [31:0] rdata_reg;
    logic        awvalid_reg, wvalid_reg, bready_reg, arvalid_reg, rready_reg;
    logic        hit, aw_done, w_done, stall;

    assign hit = mem_req_i & ((mem_addr_i & AXI_MASK) == AXI_BASE);

    // A channel is done once its valid has dropped, or it handshakes this cycle.
    assign aw_done = ~awvalid_reg | m_axi_awready_i;
    assign w_done  = ~wvalid_reg  | m_axi_wready_i;

    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        case (state_reg)
            IDLE: begin
                stall = hit;
                if (hit)
                    state_next = mem_we_i ? WR : RD;
            end
            WR: begin
                stall = 1'b1;
                if (aw_done && w_done)
                    state_next = WB;
            end
            WB: begin
                stall = 1'b1;
                if (m_axi_bvalid_i)
                    state_next = DONE;
            end
            RD: begin
                stall = 1'b1;
                if (m_axi_arready_i)
                    state_next = RR;
            end
            RR: begin
                stall = 1'b1;
                if (m_axi_rvalid_i)
                    state_next = DONE;
            end
            // Request is still on the inputs here; returning to IDLE without issuing avoids a repeat.
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            rdata_reg   <= '0;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            bready_reg  <= 1'b0;
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (hit) begin
                        addr_reg    <= mem_addr_i;
                        wdata_reg   <= mem_wdata_i;
                        wstrb_reg   <= mem_wstrb_i;
                        awvalid_reg <= mem_we_i;
                        wvalid_reg  <= mem_we_i;
                        arvalid_reg <= ~mem_we_i;
                    end
                end
                WR: begin
                    if (m_axi_awready_i)
                        awvalid_reg <= 1'b0;
                    if (m_axi_wready_i)
                        wvalid_reg <= 1'b0;
                    if (aw_done && w_done)
                        bready_reg <= 1'b1;
                end
                WB: begin
                    if (m_axi_bvalid_i)
                        bready_reg <= 1'b0;
                end
                RD: begin
                    if (m_axi_arready_i) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                    end
                end
                RR: begin
                    if (m_axi_rvalid_i) begin
                        rready_reg <= 1'b0;
                        rdata_reg  <= m_axi_rdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LSU_AXI_ERR_EN
    logic        err_reg;
    logic [31:0] err_addr_reg;
    logic        resp_err;
    logic        unused_resp;

    // Only bit 1 distinguishes SLVERR/DECERR from OKAY/EXOKAY.
    assign unused_resp = m_axi_bresp_i[0] ^ m_axi_rresp_i[0];
    assign resp_err = ((state_reg == WB) && m_axi_bvalid_i && m_axi_bresp_i[1]) ||
                      ((state_reg == RR) && m_axi_rvalid_i && m_axi_rresp_i[1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg      <= 1'b0;
            err_addr_reg <= '0;
        end else begin
            err_reg <= resp_err;
            if (resp_err)
                err_addr_reg <= addr_reg;
        end
    end

    assign err_o      = err_reg;
    assign err_addr_o = err_addr_reg;
`else
    logic unused_resp;

    assign unused_resp = ^{m_axi_bresp_i, m_axi_rresp_i};
    assign err_o       = 1'b0;
    assign err_addr_o  = '0;
`endif

    assign m_axi_stall_o   = stall;
    assign mem_rdata_o     = rdata_reg;
    assign m_axi_awaddr_o  = addr_reg;
    assign m_axi_araddr_o  = addr_reg;
    assign m_axi_wdata_o   = wdata_reg;
    assign m_axi_wstrb_o   = wstrb_reg;
    assign m_axi_awvalid_o = awvalid_reg;
    assign m_axi_wvalid_o  = wvalid_reg;
    assign m_axi_bready_o  = bready_reg;
    assign m_axi_arvalid_o = arvalid_reg;
    assign m_axi_rready_o  = rready_reg;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Self-checking bench for lsu_axi_master: directed scenarios plus randomized accesses
// against a latency/data model derived from the AXI handshake rules.
module tb_lsu_axi_master;

`ifdef LSU_AXI_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        stall;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        err;
    logic [31:0] err_addr;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state and per-access observations
    logic [31:0] exp_rdata;
    int          res_stall, res_cycles, res_valid_cycles, res_unstable, res_err_pulses;
    int          res_aw_hs, res_w_hs, res_b_hs, res_ar_hs, res_r_hs;
    logic [31:0] res_rdata, res_ar_addr;
    bit          res_timeout, res_done_busy;

    always #5 clk = ~clk;

    lsu_axi_master dut (
        .clk(clk), .rst(rst),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_wstrb_i(mem_wstrb), .mem_rdata_o(mem_rdata),
        .m_axi_stall_o(stall),
        .m_axi_awaddr_o(awaddr), .m_axi_awvalid_o(awvalid), .m_axi_awready_i(awready),
        .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb), .m_axi_wvalid_o(wvalid), .m_axi_wready_i(wready),
        .m_axi_bresp_i(bresp), .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready),
        .m_axi_araddr_o(araddr), .m_axi_arvalid_o(arvalid), .m_axi_arready_i(arready),
        .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp), .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready),
        .err_o(err), .err_addr_o(err_addr)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic slave_idle();
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bvalid  = 1'b0; bresp  = 2'b00;
        rvalid  = 1'b0; rresp  = 2'b00; rdata = 32'h0;
    endtask

    // Presents one request and plays an AXI slave with the given wait counts until the
    // first non-stall cycle at or after min_cyc. Enters and leaves at a falling edge.
    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input int d_aw, input int d_w, input int d_b,
                          input int d_ar, input int d_r, input logic [31:0] rd,
                          input logic [1:0] resp, input int min_cyc);
        int  aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0, cyc = 0;
        bit  done = 1'b0;
        res_stall = 0; res_cycles = 0; res_valid_cycles = 0; res_unstable = 0; res_err_pulses = 0;
        res_aw_hs = 0; res_w_hs = 0; res_b_hs = 0; res_ar_hs = 0; res_r_hs = 0;
        res_rdata = 32'h0; res_ar_addr = 32'h0; res_done_busy = 1'b0;
        mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wd; mem_wstrb = ws;
        while (!done && cyc < 200) begin
            awready = awvalid && (aw_wait >= d_aw);
            wready  = wvalid  && (w_wait  >= d_w);
            arready = arvalid && (ar_wait >= d_ar);
            bvalid  = bready  && (b_wait  >= d_b);
            bresp   = bvalid ? resp : 2'b00;
            rvalid  = rready  && (r_wait  >= d_r);
            rresp   = rvalid ? resp : 2'b00;
            rdata   = rvalid ? rd : $urandom;
            #1;
            if (awvalid) begin
                if (awaddr !== addr) res_unstable++;
                if (awready) res_aw_hs++;
                aw_wait++;
            end
            if (wvalid) begin
                if (wdata !== wd || wstrb !== ws) res_unstable++;
                if (wready) res_w_hs++;
                w_wait++;
            end
            if (arvalid) begin
                if (araddr !== addr) res_unstable++;
                if (arready) begin res_ar_hs++; res_ar_addr = araddr; end
                ar_wait++;
            end
            if (bready) begin if (bvalid) res_b_hs++; b_wait++; end
            if (rready) begin if (rvalid) res_r_hs++; r_wait++; end
            if (awvalid || wvalid || arvalid) res_valid_cycles++;
            if (stall) res_stall++;
            if (err) res_err_pulses++;
            if (!stall && cyc >= min_cyc) begin
                done = 1'b1;
                res_rdata = mem_rdata;
                res_done_busy = awvalid | wvalid | arvalid | bready | rready;
            end
            cyc++;
            if (!done) @(negedge clk);
        end
        res_cycles  = cyc;
        res_timeout = !done;
        mem_req = 1'b0;
        slave_idle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
        slave_idle();
        exp_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
            n_fail++; $display("FAIL reset_handshakes: got %b required 00000", {awvalid, wvalid, bready, arvalid, rready});
        end
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b required 0", stall); end
        n_checks++;
        if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h required 0", mem_rdata); end
        n_checks++;
        if (err !== 1'b0 || err_addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_err: got %b/%h required 0/0", err, err_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("reset: outputs checked");
    endtask

    task automatic test_zero_wait_load();
        access(1'b0, 32'h4000_0010, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00, 0);
        exp_rdata = 32'hDEAD_BEEF;
        n_checks++;
        if (res_timeout || res_stall != 3) begin
            n_fail++; $display("FAIL load_stall: got %0d (timeout %0d) required 3", res_stall, res_timeout);
        end
        n_checks++;
        if (res_valid_cycles != 1) begin n_fail++; $display("FAIL load_arvalid_cycles: got %0d required 1", res_valid_cycles); end
        n_checks++;
        if (res_ar_hs != 1 || res_r_hs != 1) begin
            n_fail++; $display("FAIL load_handshakes: got ar %0d r %0d required 1 1", res_ar_hs, res_r_hs);
        end
        n_checks++;
        if (res_rdata !== exp_rdata) begin n_fail++; $display("FAIL load_rdata: got %h required %h", res_rdata, exp_rdata); end
        $display("load 40000010: stall %0d rdata %h", res_stall, res_rdata);
    endtask

    task automatic test_delayed_store();
        access(1'b1, 32'h4000_0008, 32'h1234_5678, 4'b0011, 0, 3, 0, 0, 0, 32'h0, 2'b00, 0);
        n_checks++;
        if (res_timeout || res_stall != 6) begin
            n_fail++; $display("FAIL store_stall: got %0d (timeout %0d) required 6", res_stall, res_timeout);
        end
        n_checks++;
        if (res_aw_hs != 1 || res_w_hs != 1 || res_b_hs != 1) begin
            n_fail++; $display("FAIL store_handshakes: got aw %0d w %0d b %0d required 1 1 1", res_aw_hs, res_w_hs, res_b_hs);
        end
        n_checks++;
        if (res_unstable != 0) begin n_fail++; $display("FAIL store_stability: got %0d changes required 0", res_unstable); end
        n_checks++;
        if (res_rdata !== exp_rdata) begin n_fail++; $display("FAIL store_rdata_kept: got %h required %h", res_rdata, exp_rdata); end
        $display("store 40000008: stall %0d aw %0d w %0d", res_stall, res_aw_hs, res_w_hs);
    endtask

    task automatic test_out_of_window();
        access(1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'hCAFE_F00D, 2'b00, 5);
        n_checks++;
        if (res_stall != 0) begin n_fail++; $display("FAIL oow_stall: got %0d required 0", res_stall); end
        n_checks++;
        if (res_valid_cycles != 0 || res_ar_hs != 0) begin
            n_fail++; $display("FAIL oow_valids: got %0d cycles required 0", res_valid_cycles);
        end
        n_checks++;
        if (res_rdata !== exp_rdata) begin n_fail++; $display("FAIL oow_rdata: got %h required %h", res_rdata, exp_rdata); end
        $display("load 00000100 (outside window): stall %0d", res_stall);
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [2];
        addrs[0] = 32'h4000_0000;
        addrs[1] = 32'h4000_0004;
        for (int i = 0; i < 2; i++) begin
            logic [31:0] d;
            d = $urandom;
            access(1'b0, addrs[i], 32'h0, 4'h0, 0, 0, 0, 0, 0, d, 2'b00, 0);
            exp_rdata = d;
            n_checks++;
            if (res_ar_hs != 1 || res_ar_addr !== addrs[i]) begin
                n_fail++; $display("FAIL b2b_ar%0d: got %0d at %h required 1 at %h", i, res_ar_hs, res_ar_addr, addrs[i]);
            end
            n_checks++;
            if (res_cycles != 4 || res_done_busy) begin
                n_fail++; $display("FAIL b2b_done%0d: got %0d cycles busy %0d required 4 cycles busy 0", i, res_cycles, res_done_busy);
            end
            n_checks++;
            if (res_rdata !== exp_rdata) begin n_fail++; $display("FAIL b2b_rdata%0d: got %h required %h", i, res_rdata, exp_rdata); end
            $display("b2b load %h: cycles %0d rdata %h", addrs[i], res_cycles, res_rdata);
        end
    endtask

    task automatic test_reset_in_rr();
        bit seen = 1'b0;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h4000_0030;
        for (int i = 0; i < 10 && !seen; i++) begin
            arready = arvalid;
            #1;
            if (rready) seen = 1'b1;
            else @(negedge clk);
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL rr_reached: got 0 required 1"); end
        rst = 1'b1; mem_req = 1'b0; arready = 1'b0;
        exp_rdata = 32'h0;
        #1;
        n_checks++;
        if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
            n_fail++; $display("FAIL rr_reset_drop: got %b required 00000", {awvalid, wvalid, bready, arvalid, rready});
        end
        n_checks++;
        if (stall !== 1'b0 || mem_rdata !== exp_rdata) begin
            n_fail++; $display("FAIL rr_reset_state: got stall %b rdata %h required 0 0", stall, mem_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("reset in RR: handshakes dropped, rdata %h", mem_rdata);
    endtask

    task automatic test_error();
        access(1'b0, 32'h4000_0020, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'h0BAD_0BAD, 2'b10, 0);
        exp_rdata = 32'h0BAD_0BAD;
        n_checks++;
        if (res_err_pulses != (ERR_EN ? 1 : 0)) begin
            n_fail++; $display("FAIL err_pulse: got %0d required %0d", res_err_pulses, ERR_EN ? 1 : 0);
        end
        #1;
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: got %b required 0", err); end
        n_checks++;
        if (err_addr !== (ERR_EN ? 32'h4000_0020 : 32'h0)) begin
            n_fail++; $display("FAIL err_addr: got %h required %h", err_addr, ERR_EN ? 32'h4000_0020 : 32'h0);
        end
        n_checks++;
        if (res_rdata !== exp_rdata) begin n_fail++; $display("FAIL err_rdata: got %h required %h", res_rdata, exp_rdata); end
        @(negedge clk);
        $display("error load 40000020: pulses %0d err_addr %h", res_err_pulses, err_addr);
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            bit          we, inwin;
            logic [31:0] addr, wd, rd;
            logic [3:0]  ws;
            logic [1:0]  resp;
            int          d_aw, d_w, d_b, d_ar, d_r, exp_stall, exp_hs, exp_err, got_hs;
            we    = 1'($urandom);
            inwin = ($urandom_range(3) != 0);
            addr  = {inwin ? 4'h4 : 4'h0, 28'($urandom)};
            wd    = $urandom; rd = $urandom; ws = 4'($urandom); resp = 2'($urandom);
            d_aw  = $urandom_range(3); d_w = $urandom_range(3); d_b = $urandom_range(3);
            d_ar  = $urandom_range(3); d_r = $urandom_range(3);
            access(we, addr, wd, ws, d_aw, d_w, d_b, d_ar, d_r, rd, resp, inwin ? 0 : 3);
            // Latency: one issue cycle, then each channel costs its wait cycles plus its handshake.
            if (!inwin) begin
                exp_stall = 0; exp_hs = 0; exp_err = 0;
            end else if (we) begin
                exp_stall = 1 + ((d_aw > d_w) ? d_aw : d_w) + 1 + d_b + 1;
                exp_hs = 3; exp_err = (ERR_EN && resp[1]) ? 1 : 0;
            end else begin
                exp_stall = 1 + d_ar + 1 + d_r + 1;
                exp_hs = 2; exp_err = (ERR_EN && resp[1]) ? 1 : 0;
                exp_rdata = rd;
            end
            got_hs = res_aw_hs + res_w_hs + res_b_hs + res_ar_hs + res_r_hs;
            n_checks++;
            if (res_timeout || res_stall != exp_stall) begin
                n_fail++; $display("FAIL rnd%0d_stall: got %0d (timeout %0d) required %0d", n, res_stall, res_timeout, exp_stall);
            end
            n_checks++;
            if (got_hs != exp_hs || res_unstable != 0) begin
                n_fail++; $display("FAIL rnd%0d_handshakes: got %0d (unstable %0d) required %0d", n, got_hs, res_unstable, exp_hs);
            end
            n_checks++;
            if (res_rdata !== exp_rdata) begin n_fail++; $display("FAIL rnd%0d_rdata: got %h required %h", n, res_rdata, exp_rdata); end
            n_checks++;
            if (res_err_pulses != exp_err) begin n_fail++; $display("FAIL rnd%0d_err: got %0d required %0d", n, res_err_pulses, exp_err); end
            $display("rnd %0d: we %0d addr %h stall %0d rdata %h", n, we, addr, res_stall, res_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_load();
        test_delayed_store();
        test_out_of_window();
        test_back_to_back();
        test_reset_in_rr();
        test_error();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
